// File: rtl/layer_serializer.sv
// Collects one output word per neuron of a layer (in any order) and streams the
// completed batch to the next layer as a valid/ready word sequence, neuron 0 first.
module layer_serializer #(
    parameter int NN = 30,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NN*DW-1:0] x_in,
    input  logic [NN-1:0]    in_valid,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done,
    output logic             overflow
);

    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  word_q [NN];
    logic [DW-1:0]  word_d [NN];
    logic [NN-1:0]  captured_q, captured_d;
    logic [NN-1:0]  wr_en;
    logic [IW-1:0]  idx_q, idx_d;
    logic           done_q, done_d;
    logic           overflow_q, overflow_d;
    logic           xfer;
    logic           final_xfer;

    assign xfer       = (state_q == SEND) && out_ready;
    assign final_xfer = xfer && (idx_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        wr_en      = '0;
        case (state_q)
            COLLECT: begin
                wr_en      = in_valid & ~captured_q;
                captured_d = captured_q | in_valid;
                if (|(in_valid & captured_q)) begin
                    overflow_d = 1'b1;
                end
                if (&captured_d) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (final_xfer) begin
                    // Strobes on the last transfer seed the next batch instead of being lost.
                    done_d     = 1'b1;
                    idx_d      = '0;
                    wr_en      = in_valid;
                    captured_d = in_valid;
                    state_d    = (&in_valid) ? SEND : COLLECT;
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (|in_valid) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NN; k++) begin
            word_d[k] = wr_en[k] ? x_in[k*DW +: DW] : word_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            captured_q <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int k = 0; k < NN; k++) begin
                word_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            for (int k = 0; k < NN; k++) begin
                word_q[k] <= word_d[k];
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_data  = out_valid ? word_q[idx_q] : '0;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Randomized scoreboard bench for layer_serializer: a batch-level reference model
// queues expected words; a negedge monitor compares every presented output.
module tb_layer_serializer;

    localparam int NN = 30;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NN*DW-1:0] x_in = '0;
    logic [NN-1:0]    in_valid = '0;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_last;
    logic             done;
    logic             overflow;

    layer_serializer #(.NN(NN), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .x_in     (x_in),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    bit            m_cap [NN];
    logic [DW-1:0] m_val [NN];
    int            words_left = 0;
    bit            exp_ovf = 1'b0;
    bit            done_pending = 1'b0;
    bit            mon_en = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model: a batch is the set of first-arriving words per neuron;
    // once every neuron has reported, the batch is queued for output in neuron order.
    function automatic void model_collect(input logic [NN-1:0] inv, input logic [NN*DW-1:0] xv);
        bit all_in;
        for (int k = 0; k < NN; k++) begin
            if (inv[k]) begin
                if (m_cap[k]) exp_ovf = 1'b1;
                else begin
                    m_cap[k] = 1'b1;
                    m_val[k] = xv[k*DW +: DW];
                end
            end
        end
        all_in = 1'b1;
        for (int k = 0; k < NN; k++) if (!m_cap[k]) all_in = 1'b0;
        if (all_in) begin
            for (int k = 0; k < NN; k++) begin
                exp_q.push_back('{data: m_val[k], last: (k == NN - 1)});
                m_cap[k] = 1'b0;
            end
            words_left = NN;
        end
    endfunction

    function automatic void model_edge(input logic [NN-1:0] inv, input logic [NN*DW-1:0] xv, input bit rdy);
        if (words_left > 0) begin
            if (rdy && words_left == 1) begin
                words_left = 0;
                model_collect(inv, xv);
            end else begin
                if (inv != '0) exp_ovf = 1'b1;
                if (rdy) words_left--;
            end
        end else begin
            model_collect(inv, xv);
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        words_left   = 0;
        exp_ovf      = 1'b0;
        done_pending = 1'b0;
        for (int k = 0; k < NN; k++) m_cap[k] = 1'b0;
    endfunction

    task automatic cycle(input logic [NN-1:0] inv, input logic [NN*DW-1:0] xv, input bit rdy);
        in_valid  = inv;
        x_in      = xv;
        out_ready = rdy;
        @(posedge clk);
        #1;
        model_edge(inv, xv, rdy);
        in_valid = '0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle('0, '0, rdy);
    endtask

    function automatic logic [NN*DW-1:0] rand_words();
        logic [NN*DW-1:0] v;
        for (int k = 0; k < NN; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [NN-1:0] onehot(input int k);
        logic [NN-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        bit nxt_done;
        if (mon_en && rst) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("done", 32'(done), 32'(done_pending));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            nxt_done = 1'b0;
            if (out_valid && exp_q.size() > 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                chk("out_last", 32'(out_last), 32'(exp_q[0].last));
                if (out_ready) begin
                    nxt_done = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
            end
            done_pending = nxt_done;
        end
    end

    initial begin
        logic [NN*DW-1:0] xv;
        logic [NN*DW-1:0] xv2;
        logic [NN-1:0]    inv;
        int               order [NN-1];
        int               tmp;
        int               j;

        model_clear();
        // reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        mon_en = 1'b1;

        // all strobes at once, word k = k+1
        for (int k = 0; k < NN; k++) xv[k*DW +: DW] = DW'(k + 1);
        cycle('1, xv, 1'b1);
        idle(32, 1'b1);

        // reverse-order arrival, word k = 0x100+k
        for (int k = 0; k < NN; k++) xv[k*DW +: DW] = DW'(16'h100 + k);
        for (int k = NN - 1; k >= 0; k--) cycle(onehot(k), xv, 1'b1);
        idle(32, 1'b1);

        // ready pattern 1,0,0,1
        cycle('1, rand_words(), 1'b1);
        for (int i = 0; i < 130; i++) cycle('0, '0, (i % 4 == 0) || (i % 4 == 3));

        // duplicate strobe on neuron 3 before completion, stray strobe on 5 at idx 10
        xv = rand_words();
        xv[3*DW +: DW] = 16'hAAAA;
        xv2 = xv;
        xv2[3*DW +: DW] = 16'hBBBB;
        cycle(onehot(3), xv, 1'b1);
        cycle(onehot(3), xv2, 1'b1);
        j = 0;
        for (int k = 0; k < NN; k++) if (k != 3) begin order[j] = k; j++; end
        for (int i = NN - 2; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < NN - 1; i++) cycle(onehot(order[i]), xv, 1'b1);
        for (int i = 0; i < 40; i++) cycle((words_left == 20) ? onehot(5) : '0, rand_words(), 1'b1);

        // back-to-back: next full batch on the final-transfer cycle
        cycle('1, rand_words(), 1'b1);
        for (int i = 0; i < 40 && words_left != 1; i++) cycle('0, '0, 1'b1);
        cycle('1, rand_words(), 1'b1);
        idle(35, 1'b1);

        // asynchronous reset at idx 12
        cycle('1, rand_words(), 1'b1);
        for (int i = 0; i < 40 && words_left != NN - 12; i++) cycle('0, '0, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_last", 32'(out_last), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        xv = rand_words();
        for (int k = 0; k < NN - 1; k++) cycle(onehot(k), xv, $urandom_range(0, 1) == 1);
        idle(5, 1'b1);
        cycle(onehot(NN - 1), xv, 1'b1);
        idle(35, 1'b1);

        // randomized strobes, stalls and stray strobes
        for (int i = 0; i < 600; i++) begin
            if (words_left == 0) inv = NN'($urandom) & NN'($urandom) & NN'($urandom);
            else if (words_left == 1 && $urandom_range(0, 3) == 0) inv = '1;
            else inv = ($urandom_range(0, 15) == 0) ? onehot($urandom_range(0, NN - 1)) : '0;
            cycle(inv, rand_words(), $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) cycle('0, '0, 1'b1);
        idle(3, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
